// File: rtl/riscv_pkg.sv
// Shared types for the operand hazard/forwarding controller:
// operand widths, in-flight slot record and issue-control FSM states.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RAW  = 5;

   // One in-flight pipeline slot; vld is set only for real register writers (rd != x0)
   typedef struct packed {
      logic           vld;
      logic [RAW-1:0] rd;
      logic           is_load;
   } slot_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      FREEZE = 2'd2
   } state_t;

   // True when the slot holds a pending write to register rs
   function automatic logic slot_hit(input slot_t s, input logic [RAW-1:0] rs);
      return s.vld && (s.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// Per-source-operand match, youngest-first forward select and load-use flag.
module hazard_fwd_mux
   import riscv_pkg::*;
(
   input  logic            id_valid,
   input  logic            rs_use,
   input  logic [RAW-1:0]  rs,
   input  slot_t           ex_slot,
   input  slot_t           mem_slot,
   input  slot_t           wb_slot,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] mem_result,
   input  logic [XLEN-1:0] wb_result,
   output logic            forward,
   output logic [XLEN-1:0] forward_data,
   output logic            load_hz
);

   logic rs_live;

   // Priority EX > MEM > WB; an EX load cannot forward and raises the hazard instead
   always_comb begin
      forward      = 1'b0;
      forward_data = '0;
      load_hz      = 1'b0;
      rs_live      = id_valid && rs_use && (rs != '0);
      if (rs_live && slot_hit(ex_slot, rs)) begin
         if (ex_slot.is_load) begin
            load_hz = 1'b1;
         end else begin
            forward      = 1'b1;
            forward_data = ex_result;
         end
      end else if (rs_live && slot_hit(mem_slot, rs)) begin
         forward      = 1'b1;
         forward_data = mem_result;
      end else if (rs_live && slot_hit(wb_slot, rs)) begin
         forward      = 1'b1;
         forward_data = wb_result;
      end
   end

endmodule

// File: rtl/operand_hazard_ctrl.sv
// Issue-side hazard/forwarding controller: tracks EX/MEM/WB destinations,
// drives operand read enables and forward selects, inserts load-use bubbles,
// freezes on data-memory wait and counts stall cycles (saturating).
module operand_hazard_ctrl
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RAW   = 5,
   parameter int unsigned CNT_W = 32
)
(
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             id_valid,
   input  logic [RAW-1:0]   id_rs1,
   input  logic [RAW-1:0]   id_rs2,
   input  logic             id_rs1_use,
   input  logic             id_rs2_use,
   input  logic [RAW-1:0]   id_rd,
   input  logic             id_rd_wen,
   input  logic             id_is_load,
   input  logic [XLEN-1:0]  ex_result,
   input  logic [XLEN-1:0]  mem_result,
   input  logic [XLEN-1:0]  wb_result,
   input  logic             mem_wait,
   output logic             rs1_ren,
   output logic             rs2_ren,
   output logic             rs1_forward,
   output logic             rs2_forward,
   output logic [XLEN-1:0]  rs1_forward_data,
   output logic [XLEN-1:0]  rs2_forward_data,
   output logic             id_stall,
   output logic [CNT_W-1:0] stall_cnt
);

   import riscv_pkg::*;

   slot_t  ex_q, mem_q, wb_q;
   slot_t  id_entry;
   state_t state_q;
   logic   rs1_lh, rs2_lh;
   logic   load_hazard;

   hazard_fwd_mux u_rs1_mux (
      .id_valid     (id_valid),
      .rs_use       (id_rs1_use),
      .rs           (id_rs1),
      .ex_slot      (ex_q),
      .mem_slot     (mem_q),
      .wb_slot      (wb_q),
      .ex_result    (ex_result),
      .mem_result   (mem_result),
      .wb_result    (wb_result),
      .forward      (rs1_forward),
      .forward_data (rs1_forward_data),
      .load_hz      (rs1_lh)
   );

   hazard_fwd_mux u_rs2_mux (
      .id_valid     (id_valid),
      .rs_use       (id_rs2_use),
      .rs           (id_rs2),
      .ex_slot      (ex_q),
      .mem_slot     (mem_q),
      .wb_slot      (wb_q),
      .ex_result    (ex_result),
      .mem_result   (mem_result),
      .wb_result    (wb_result),
      .forward      (rs2_forward),
      .forward_data (rs2_forward_data),
      .load_hz      (rs2_lh)
   );

   // Stall decision, read enables and the slot record for the ID instruction
   always_comb begin
      load_hazard      = rs1_lh | rs2_lh;
      id_stall         = (state_q == FREEZE) | mem_wait | load_hazard;
      rs1_ren          = id_valid & ~id_stall;
      rs2_ren          = id_valid & ~id_stall;
      id_entry.vld     = id_valid & id_rd_wen & (id_rd != '0);
      id_entry.rd      = id_rd;
      id_entry.is_load = id_is_load;
   end

   // Issue-control FSM; mem_wait outranks a load hazard in the same cycle
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_wait)         state_q <= FREEZE;
               else if (load_hazard) state_q <= STALL;
            end
            STALL:   state_q <= mem_wait ? FREEZE : RUN;
            FREEZE:  if (!mem_wait) state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   // In-flight slots: hold while memory waits, insert a bubble on any other stall.
   // The recovery cycle out of FREEZE doubles as the load-use bubble, so a load
   // hazard pending across a freeze costs only one extra cycle.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!mem_wait) begin
         ex_q  <= id_stall ? '0 : id_entry;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // Saturating count of stalled ID cycles
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         stall_cnt <= '0;
      end else if (id_stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Directed bench for operand_hazard_ctrl: expected outputs are queued when a
// cycle's stimulus is driven and popped/compared 2 ns after the falling edge.
module tb_operand_hazard_ctrl;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RAW   = 5;
   localparam int unsigned CNT_W = 4;

   logic             CLK;
   logic             RSTN;
   logic             id_valid;
   logic [RAW-1:0]   id_rs1, id_rs2, id_rd;
   logic             id_rs1_use, id_rs2_use, id_rd_wen, id_is_load;
   logic [XLEN-1:0]  ex_result, mem_result, wb_result;
   logic             mem_wait;
   logic             rs1_ren, rs2_ren, rs1_forward, rs2_forward, id_stall;
   logic [XLEN-1:0]  rs1_forward_data, rs2_forward_data;
   logic [CNT_W-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string            tag;
      bit               is_cnt;
      logic             ren;
      logic             f1;
      logic [XLEN-1:0]  d1;
      logic             f2;
      logic [XLEN-1:0]  d2;
      logic             stall;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];

   operand_hazard_ctrl #(.XLEN(XLEN), .RAW(RAW), .CNT_W(CNT_W)) dut (
      .CLK              (CLK),
      .RSTN             (RSTN),
      .id_valid         (id_valid),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .id_rs1_use       (id_rs1_use),
      .id_rs2_use       (id_rs2_use),
      .id_rd            (id_rd),
      .id_rd_wen        (id_rd_wen),
      .id_is_load       (id_is_load),
      .ex_result        (ex_result),
      .mem_result       (mem_result),
      .wb_result        (wb_result),
      .mem_wait         (mem_wait),
      .rs1_ren          (rs1_ren),
      .rs2_ren          (rs2_ren),
      .rs1_forward      (rs1_forward),
      .rs2_forward      (rs2_forward),
      .rs1_forward_data (rs1_forward_data),
      .rs2_forward_data (rs2_forward_data),
      .id_stall         (id_stall),
      .stall_cnt        (stall_cnt)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic set_id(input logic v, input logic [RAW-1:0] r1, input logic u1,
                         input logic [RAW-1:0] r2, input logic u2,
                         input logic [RAW-1:0] rd, input logic wen, input logic ld);
      id_valid   = v;
      id_rs1     = r1;
      id_rs1_use = u1;
      id_rs2     = r2;
      id_rs2_use = u2;
      id_rd      = rd;
      id_rd_wen  = wen;
      id_is_load = ld;
   endtask

   task automatic set_idle();
      set_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic exp_o(input string tag, input logic ren, input logic f1,
                        input logic [XLEN-1:0] d1, input logic f2,
                        input logic [XLEN-1:0] d2, input logic stall);
      exp_t e;
      e.tag = tag; e.is_cnt = 1'b0; e.ren = ren; e.f1 = f1; e.d1 = d1;
      e.f2 = f2; e.d2 = d2; e.stall = stall; e.cnt = '0;
      sb.push_back(e);
   endtask

   task automatic exp_c(input string tag, input logic [CNT_W-1:0] cnt);
      exp_t e;
      e.tag = tag; e.is_cnt = 1'b1; e.ren = 1'b0; e.f1 = 1'b0; e.d1 = '0;
      e.f2 = 1'b0; e.d2 = '0; e.stall = 1'b0; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic sample();
      exp_t e;
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_cnt) begin
            check({e.tag, ".stall_cnt"}, XLEN'(stall_cnt), XLEN'(e.cnt));
         end else begin
            check({e.tag, ".rs1_ren"},  XLEN'(rs1_ren),     XLEN'(e.ren));
            check({e.tag, ".rs2_ren"},  XLEN'(rs2_ren),     XLEN'(e.ren));
            check({e.tag, ".rs1_fwd"},  XLEN'(rs1_forward), XLEN'(e.f1));
            check({e.tag, ".rs1_data"}, rs1_forward_data,   e.d1);
            check({e.tag, ".rs2_fwd"},  XLEN'(rs2_forward), XLEN'(e.f2));
            check({e.tag, ".rs2_data"}, rs2_forward_data,   e.d2);
            check({e.tag, ".id_stall"}, XLEN'(id_stall),    XLEN'(e.stall));
         end
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic step();
      sample();
      tick();
   endtask

   task automatic drain();
      set_idle();
      repeat (3) tick();
   endtask

   task automatic pulse_reset();
      RSTN = 1'b0;
      #1;
      RSTN = 1'b1;
   endtask

   initial begin
      RSTN       = 1'b0;
      mem_wait   = 1'b0;
      ex_result  = 32'h1111_0000;
      mem_result = 32'h2222_0000;
      wb_result  = 32'h3333_0000;
      set_idle();
      tick();

      // Reset state: nothing forwards, no stall, ren follows id_valid
      set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      exp_o("reset", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      exp_c("reset", 4'd0);
      sample();
      RSTN = 1'b1;
      tick();

      // T1: ALU writer x5, then read rs1=x5 from EX
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      exp_o("t1_issue", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      step();
      ex_result = 32'h0000_1234;
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      exp_o("t1_fwd_ex", 1'b1, 1'b1, 32'h0000_1234, 1'b0, '0, 1'b0);
      step();
      drain();

      // T2: lw x6 then add rs2=x6: one bubble, then forward from MEM
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
      exp_o("t2_lw", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      step();
      set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
      exp_o("t2_stall", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      step();
      mem_result = 32'hDEAD_BEEF;
      exp_o("t2_fwd_mem", 1'b1, 1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      exp_c("t2_cnt", 4'd1);
      step();
      drain();

      // T3: three x7 writers; youngest wins, then older ones as they drain
      ex_result  = 32'h0000_000A;
      mem_result = 32'h0000_000B;
      wb_result  = 32'h0000_000C;
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      exp_o("t3_ex", 1'b1, 1'b1, 32'h0000_000A, 1'b1, 32'h0000_000A, 1'b0);
      step();
      set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      exp_o("t3_mem", 1'b1, 1'b1, 32'h0000_000B, 1'b0, '0, 1'b0);
      step();
      exp_o("t3_wb", 1'b1, 1'b1, 32'h0000_000C, 1'b0, '0, 1'b0);
      step();
      drain();

      // T4: writes to x0 are never tracked
      ex_result = 32'h0000_5555;
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      exp_o("t4_x0", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      step();
      drain();

      // T5: mem_wait for 3 cycles over a pending load hazard -> 4 stall cycles total
      pulse_reset();
      mem_result = 32'h0BAD_F00D;
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      mem_wait = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         exp_o("t5_freeze", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
         step();
      end
      mem_wait = 1'b0;
      exp_o("t5_load_stall", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      exp_c("t5_cnt_mid", 4'd3);
      step();
      exp_o("t5_fwd_mem", 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, '0, 1'b0);
      exp_c("t5_cnt", 4'd4);
      step();
      drain();

      // T6: reset while in STALL discards the in-flight load
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      exp_o("t6_stall", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      step();
      RSTN = 1'b0;
      exp_o("t6_in_reset", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      exp_c("t6_in_reset", 4'd0);
      sample();
      RSTN = 1'b1;
      tick();
      exp_o("t6_after_reset", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      step();
      drain();

      // Saturation: a long freeze drives the counter to all-ones and holds it
      pulse_reset();
      mem_wait = 1'b1;
      for (int unsigned i = 0; i < 20; i++) begin
         if (i == 14) exp_c("sat_14", 4'd14);
         if (i == 19) exp_c("sat_hold", 4'hF);
         step();
      end
      mem_wait = 1'b0;
      exp_o("sat_recover", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      step();
      exp_o("sat_run", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      exp_c("sat_final", 4'hF);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
